// File: rtl/puzzle_sequencer_if.sv
// Host byte-stream handshake for puzzle_sequencer: valid/ready with a last-byte marker.
// master = host side, slave = sequencer side.
interface puzzle_sequencer_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/puzzle_sequencer.sv
// Front-end controller for the Puzzle grid engine: clear, header, grid, moves, verdict.
// Optional move cap is compiled in when SEQ_MOVE_LIMIT_EN is defined.
module puzzle_sequencer #(
    parameter int HEIGHT    = 10,
    parameter int WIDTH     = 10,
    parameter int MAX_MOVES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    puzzle_sequencer_if.slave    host,
    output logic [7:0]           eng_data,
    output logic                 eng_enable,
    output logic                 eng_enable_process,
    output logic                 eng_rst,
    input  logic                 eng_result,
    output logic                 busy,
    output logic                 done,
    output logic                 win,
    output logic                 err,
    output logic [15:0]          move_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_HEADER, S_GRID, S_MOVES, S_SETTLE, S_SAMPLE, S_DONE
    } state_t;

    localparam logic [15:0] GRID_LAST  = 16'(HEIGHT * WIDTH - 1);
    localparam logic [15:0] MOVE_LIMIT = 16'(MAX_MOVES);
`ifdef SEQ_MOVE_LIMIT_EN
    localparam logic        LIMIT_ON   = 1'b1;
`else
    localparam logic        LIMIT_ON   = 1'b0;
`endif

    state_t      state_r, state_s;
    logic [15:0] idx_r, idx_s;
    logic        ready_s, fwd_s, proc_s, err_set_s, limit_hit_s;

    assign limit_hit_s   = LIMIT_ON & (move_count == MOVE_LIMIT);
    assign host.in_ready = ready_s;

    // Next-state, byte-acceptance and forwarding decisions
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        ready_s   = 1'b0;
        fwd_s     = 1'b0;
        proc_s    = 1'b0;
        err_set_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) state_s = S_CLEAR;
                else       state_s = S_IDLE;
            end
            S_CLEAR: begin
                idx_s   = 16'd0;
                state_s = S_HEADER;
            end
            S_HEADER: begin
                ready_s = 1'b1;
                if (host.in_valid) begin
                    fwd_s = 1'b1;
                    if (host.in_last) begin
                        err_set_s = 1'b1;
                        state_s   = S_SETTLE;
                    end else if (idx_r == 16'd3) begin
                        idx_s   = 16'd0;
                        state_s = S_GRID;
                    end else begin
                        idx_s = idx_r + 16'd1;
                    end
                end else begin
                    state_s = S_HEADER;
                end
            end
            S_GRID: begin
                ready_s = 1'b1;
                if (host.in_valid) begin
                    fwd_s = 1'b1;
                    if (host.in_last) begin
                        err_set_s = 1'b1;
                        state_s   = S_SETTLE;
                    end else if (idx_r == GRID_LAST) begin
                        state_s = S_MOVES;
                    end else begin
                        idx_s = idx_r + 16'd1;
                    end
                end else begin
                    state_s = S_GRID;
                end
            end
            S_MOVES: begin
                ready_s = 1'b1;
                if (host.in_valid) begin
                    // A capped move is swallowed without reaching the engine
                    if (limit_hit_s) begin
                        err_set_s = 1'b1;
                        state_s   = S_SETTLE;
                    end else begin
                        proc_s = 1'b1;
                        if (host.in_last) state_s = S_SETTLE;
                        else              state_s = S_MOVES;
                    end
                end else begin
                    state_s = S_MOVES;
                end
            end
            S_SETTLE: state_s = S_SAMPLE;
            S_SAMPLE: state_s = S_DONE;
            S_DONE: begin
                if (start) state_s = S_CLEAR;
                else       state_s = S_DONE;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State, engine strobes and sticky session status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r            <= S_IDLE;
            idx_r              <= 16'd0;
            eng_data           <= 8'd0;
            eng_enable         <= 1'b0;
            eng_enable_process <= 1'b0;
            eng_rst            <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            win                <= 1'b0;
            err                <= 1'b0;
            move_count         <= 16'd0;
        end else begin
            state_r            <= state_s;
            idx_r              <= idx_s;
            busy               <= (state_s != S_IDLE) && (state_s != S_DONE);
            eng_rst            <= (state_s == S_CLEAR);
            eng_enable         <= (state_s == S_CLEAR) || fwd_s;
            eng_enable_process <= proc_s;
            if (fwd_s || proc_s) eng_data <= host.in_data;
            if (state_s == S_CLEAR) begin
                done       <= 1'b0;
                win        <= 1'b0;
                err        <= 1'b0;
                move_count <= 16'd0;
            end else begin
                if (err_set_s) err <= 1'b1;
                if (proc_s && (move_count != 16'hFFFF)) move_count <= move_count + 16'd1;
                if (state_r == S_SAMPLE) begin
                    win  <= eng_result & ~err;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_puzzle_sequencer.sv
// Randomized self-checking bench for puzzle_sequencer with a behavioural engine and verdict model.
module tb_puzzle_sequencer;
    localparam int H = 10;
    localparam int W = 10;
    localparam int N = H * W;
`ifdef SEQ_MOVE_LIMIT_EN
    localparam int LIM      = 3;
    localparam bit LIMIT_ON = 1'b1;
`else
    localparam int LIM      = 255;
    localparam bit LIMIT_ON = 1'b0;
`endif

    typedef logic [7:0] b8;

    logic        clk = 1'b0;
    logic        rst, start;
    logic        eng_result = 1'b0;
    logic [7:0]  eng_data;
    logic        eng_enable, eng_enable_process, eng_rst;
    logic        busy, done, win, err;
    logic [15:0] move_count;

    puzzle_sequencer_if hif ();

    puzzle_sequencer #(.HEIGHT(H), .WIDTH(W), .MAX_MOVES(LIM)) dut (
        .clk(clk), .rst(rst), .start(start), .host(hif.slave),
        .eng_data(eng_data), .eng_enable(eng_enable),
        .eng_enable_process(eng_enable_process), .eng_rst(eng_rst),
        .eng_result(eng_result), .busy(busy), .done(done), .win(win),
        .err(err), .move_count(move_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Puzzle verdict: walk the moves over the grid; leaving the board or hitting a 0 cell loses.
    function automatic bit solved(input b8 s[$]);
        int x, y;
        if (s.size() < 4 + N) return 1'b0;
        x = int'(s[0]);
        y = int'(s[1]);
        for (int i = 4 + N; i < s.size(); i++) begin
            case (s[i])
                8'd78:   y = y - 1;
                8'd83:   y = y + 1;
                8'd69:   x = x + 1;
                8'd87:   x = x - 1;
                default: ;
            endcase
            if (x < 0 || x >= W || y < 0 || y >= H) return 1'b0;
            if (s[4 + y * W + x] == 8'd0) return 1'b0;
        end
        return (x == int'(s[2])) && (y == int'(s[3]));
    endfunction

    // Engine stand-in: record what it consumes, report the verdict of that stream
    b8 e_stream[$];
    always @(posedge clk) begin
        if (eng_rst) e_stream.delete();
        else if (eng_enable || eng_enable_process) e_stream.push_back(eng_data);
    end
    always @(negedge clk) eng_result <= solved(e_stream);

    // Expected session outcome
    b8          hg[$];
    b8          mv[$];
    b8          tx_d[$];
    bit         tx_l[$];
    logic [8:0] exp_fwd[$];
    bit         exp_err, exp_win;
    int         exp_mc;

    task automatic plan(input int err_at);
        b8 fs[$];
        bit l;
        tx_d.delete(); tx_l.delete(); exp_fwd.delete();
        exp_err = 1'b0; exp_mc = 0;
        for (int i = 0; i < hg.size(); i++) begin
            l = (i == err_at);
            tx_d.push_back(hg[i]); tx_l.push_back(l);
            fs.push_back(hg[i]); exp_fwd.push_back({1'b0, hg[i]});
            if (l) begin exp_err = 1'b1; break; end
        end
        if (!exp_err) begin
            for (int j = 0; j < mv.size(); j++) begin
                l = (j == mv.size() - 1);
                tx_d.push_back(mv[j]); tx_l.push_back(l);
                if (LIMIT_ON && j == LIM) begin exp_err = 1'b1; break; end
                fs.push_back(mv[j]); exp_fwd.push_back({1'b1, mv[j]}); exp_mc++;
                if (l) break;
            end
        end
        exp_win = !exp_err && solved(fs);
    endtask

    task automatic path_puzzle();
        hg.delete();
        hg.push_back(8'd0); hg.push_back(8'd0); hg.push_back(8'd9); hg.push_back(8'd9);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                hg.push_back((x == 0 || y == H - 1) ? 8'd1 : 8'd0);
    endtask

    task automatic good_moves();
        mv.delete();
        for (int i = 0; i < 9; i++) mv.push_back(8'd83);
        for (int i = 0; i < 9; i++) mv.push_back(8'd69);
    endtask

    // Per-cycle compare: strobes exclusive, only after a transfer, carrying the expected byte
    logic prev_xfer = 1'b0;
    always @(posedge clk) prev_xfer <= hif.in_valid && hif.in_ready && !rst;
    always @(negedge clk) begin
        if (!rst) begin
            chk("strobe_excl", {31'd0, eng_enable & eng_enable_process}, 32'd0);
            if (eng_rst) chk("clear_en", {31'd0, eng_enable}, 32'd1);
            if ((eng_enable && !eng_rst) || eng_enable_process) begin
                chk("strobe_after_xfer", {31'd0, prev_xfer}, 32'd1);
                if (exp_fwd.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL fwd_extra: got byte %0d, expected no forward", eng_data);
                end else begin
                    chk("fwd_byte", {23'd0, eng_enable_process, eng_data}, {23'd0, exp_fwd.pop_front()});
                end
            end
        end
    end

    task automatic send(input b8 d, input bit l, input bit gaps, input bit poke);
        int guard = 0;
        if (gaps) while ($urandom_range(0, 2) == 0) begin hif.in_valid = 1'b0; @(negedge clk); end
        hif.in_valid = 1'b1; hif.in_data = d; hif.in_last = l; start = poke;
        while (!hif.in_ready && guard < 20) begin @(negedge clk); guard++; end
        if (!hif.in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_timeout: got in_ready 0, expected 1");
        end
        @(posedge clk);
        @(negedge clk);
        hif.in_valid = 1'b0; hif.in_last = 1'b0; start = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ready"}, {31'd0, hif.in_ready}, 32'd0);
        chk({tag, "_data"}, {24'd0, eng_data}, 32'd0);
        chk({tag, "_strobes"}, {29'd0, eng_enable, eng_enable_process, eng_rst}, 32'd0);
        chk({tag, "_status"}, {28'd0, busy, done, win, err}, 32'd0);
        chk({tag, "_mc"}, {16'd0, move_count}, 32'd0);
    endtask

    task automatic run(input bit gaps, input bit poke, input int abort_at);
        int g = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < tx_d.size(); i++) begin
            if (abort_at >= 0 && i == 4 + N + abort_at) begin
                @(negedge clk); rst = 1'b1;
                @(negedge clk);
                check_zero("rst_mid");
                rst = 1'b0;
                exp_fwd.delete();
                return;
            end
            send(tx_d[i], tx_l[i], gaps, poke && (i == 20));
        end
        chk("ready_drop", {31'd0, hif.in_ready}, 32'd0);
        while (!done && g < 8) begin @(negedge clk); g++; end
        chk("done", {31'd0, done}, 32'd1);
        chk("win", {31'd0, win}, {31'd0, exp_win});
        chk("err", {31'd0, err}, {31'd0, exp_err});
        chk("move_count", {16'd0, move_count}, exp_mc);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("fwd_all", exp_fwd.size(), 32'd0);
        repeat (3) @(negedge clk);
        chk("done_hold", {31'd0, done}, 32'd1);
        chk("mc_hold", {16'd0, move_count}, exp_mc);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        hif.in_valid = 1'b0; hif.in_data = 8'd0; hif.in_last = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Solvable path: nine S then nine E
        path_puzzle(); good_moves(); plan(-1);
        run(1'b0, 1'b0, -1);
`ifndef SEQ_MOVE_LIMIT_EN
        chk("pin_win", {31'd0, win}, 32'd1);
        chk("pin_mc", {16'd0, move_count}, 32'd18);
`endif

        // Extra N before the final E
        mv.insert(17, 8'd78); plan(-1);
        run(1'b0, 1'b0, -1);
`ifndef SEQ_MOVE_LIMIT_EN
        chk("pin_extra_win", {31'd0, win}, 32'd0);
        chk("pin_extra_mc", {16'd0, move_count}, 32'd19);
`endif

        // in_last on grid byte 50
        good_moves(); plan(4 + 50);
        run(1'b0, 1'b0, -1);
        chk("pin_grid_err", {31'd0, err}, 32'd1);
        chk("pin_grid_mc", {16'd0, move_count}, 32'd0);

        // Host gaps plus a start pulse while busy
        plan(-1);
        run(1'b1, 1'b1, -1);

        // Reset in the middle of the moves, then a clean session
        plan(-1);
        run(1'b0, 1'b0, 2);
        plan(-1);
        run(1'b1, 1'b0, -1);

        // Randomized sessions
        for (int k = 0; k < 8; k++) begin
            path_puzzle();
            if ($urandom_range(0, 1) == 1) begin
                good_moves();
                if ($urandom_range(0, 1) == 1) mv[$urandom_range(0, 17)] = 8'd87;
            end else begin
                mv.delete();
                for (int j = 0; j < int'($urandom_range(1, 24)); j++)
                    case ($urandom_range(0, 3))
                        0:       mv.push_back(8'd78);
                        1:       mv.push_back(8'd83);
                        2:       mv.push_back(8'd69);
                        default: mv.push_back(8'd87);
                    endcase
            end
            plan(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4 + N - 1)) : -1);
            run(1'(($urandom_range(0, 1))), 1'b0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end
endmodule
